// File: rtl/sar_conv_scheduler.sv
// sar_conv_scheduler: round-robin conversion scheduler for the 12-bit SAR ADC.
// Arbitrates NCH requesters, drives mux select / sampling window / conversion
// start, captures the SAR result on the EOC rising edge and offers it on a
// single-entry valid/ready result slot.
// Optional EOC watchdog: define SAR_SCHED_TIMEOUT_EN to abort a conversion that
// sees no EOC edge within TIMEOUT_CYC cycles (TIMEOUT_ERR pulses).
module sar_conv_scheduler #(
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int SAMPLE_CYC = 4
`ifdef SAR_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic            CLK_S,
    input  logic            RST,
    input  logic [NCH-1:0]  REQ,
    output logic [NCH-1:0]  GNT,
    output logic [CH_W-1:0] CH_SEL,
    output logic            SAMPLE,
    output logic            CONV_START,
    input  logic            EOC,
    input  logic [11:0]     DIN,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic [11:0]     RES_DATA,
    output logic [CH_W-1:0] RES_CH,
    output logic            BUSY,
    output logic            TIMEOUT_ERR
);

    // Sample counter is loaded with SAMPLE_CYC-1 and counts down to zero.
    localparam int SC_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SAMPLE   = 2'd1,
        S_START    = 2'd2,
        S_WAIT_EOC = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NCH-1:0]    gnt_q, gnt_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              sample_q, sample_d;
    logic              conv_start_q, conv_start_d;
    logic              res_valid_q, res_valid_d;
    logic [11:0]       res_data_q, res_data_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic              busy_q, busy_d;
    logic              eoc_prev_q, eoc_prev_d;
    logic [SC_W-1:0]   samp_cnt_q, samp_cnt_d;

    logic              eoc_edge;
    logic              slot_free;
    logic              win_found;
    logic [CH_W-1:0]   win_idx;
    logic [CH_W-1:0]   cand;
    int                cand_i;

`ifdef SAR_SCHED_TIMEOUT_EN
    // Watchdog counter holds 0..TIMEOUT_CYC-1; terminal count is TIMEOUT_CYC-1.
    localparam int TC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TC_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // EOC history is kept in every state, so a level already high when
    // WAIT_EOC is entered never looks like a fresh edge.
    assign eoc_prev_d = EOC;
    assign eoc_edge   = EOC & ~eoc_prev_q;
    // The slot can take a new result if empty or being drained this cycle.
    assign slot_free  = ~res_valid_q | RES_READY;

    // Round-robin pick: first requesting channel at or after ptr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_i    = 0;
        for (int i = 0; i < NCH; i++) begin
            cand_i = int'(ptr_q) + i;
            if (cand_i >= NCH) cand_i = cand_i - NCH;
            cand = CH_W'(cand_i);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the conversion sequence.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        ch_sel_d     = ch_sel_q;
        sample_d     = 1'b0;
        conv_start_d = 1'b0;
        samp_cnt_d   = samp_cnt_q;
        res_data_d   = res_data_q;
        res_ch_d     = res_ch_q;
        res_valid_d  = res_valid_q & ~RES_READY;
`ifdef SAR_SCHED_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found && slot_free) begin
                    gnt_d[win_idx] = 1'b1;
                    ch_sel_d       = win_idx;
                    ptr_d          = (win_idx == CH_W'(NCH - 1)) ? '0 : win_idx + 1'b1;
                    sample_d       = 1'b1;
                    samp_cnt_d     = SC_W'(SAMPLE_CYC - 1);
                    state_d        = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (samp_cnt_q == '0) begin
                    conv_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    sample_d   = 1'b1;
                    samp_cnt_d = samp_cnt_q - 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT_EOC;
`ifdef SAR_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT_EOC: begin
                // An edge on the terminal-count cycle still captures.
                if (eoc_edge) begin
                    res_data_d  = DIN;
                    res_ch_d    = ch_sel_q;
                    res_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
`ifdef SAR_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TC_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge CLK_S or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            ch_sel_q     <= '0;
            sample_q     <= 1'b0;
            conv_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_ch_q     <= '0;
            busy_q       <= 1'b0;
            eoc_prev_q   <= 1'b0;
            samp_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            ch_sel_q     <= ch_sel_d;
            sample_q     <= sample_d;
            conv_start_q <= conv_start_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            busy_q       <= busy_d;
            eoc_prev_q   <= eoc_prev_d;
            samp_cnt_q   <= samp_cnt_d;
        end
    end

`ifdef SAR_SCHED_TIMEOUT_EN
    // Watchdog counter and abort pulse register.
    always_ff @(posedge CLK_S or posedge RST) begin
        if (RST) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign TIMEOUT_ERR = timeout_err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign GNT        = gnt_q;
    assign CH_SEL     = ch_sel_q;
    assign SAMPLE     = sample_q;
    assign CONV_START = conv_start_q;
    assign RES_VALID  = res_valid_q;
    assign RES_DATA   = res_data_q;
    assign RES_CH     = res_ch_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Self-checking bench for sar_conv_scheduler: directed scenarios followed by
// randomized request/backpressure traffic checked against a round-robin model.
module tb_sar_conv_scheduler;

    localparam int NCH        = 4;
    localparam int CH_W       = 2;
    localparam int SAMPLE_CYC = 4;
`ifdef SAR_SCHED_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 64;
`endif

    logic            CLK_S = 1'b0;
    logic            RST = 1'b1;
    logic [NCH-1:0]  REQ = '0;
    logic [NCH-1:0]  GNT;
    logic [CH_W-1:0] CH_SEL;
    logic            SAMPLE;
    logic            CONV_START;
    logic            EOC = 1'b0;
    logic [11:0]     DIN = '0;
    logic            RES_VALID;
    logic            RES_READY = 1'b1;
    logic [11:0]     RES_DATA;
    logic [CH_W-1:0] RES_CH;
    logic            BUSY;
    logic            TIMEOUT_ERR;

    int vectors     = 0;
    int miscompares = 0;
    int mdl_ptr     = 0;

    sar_conv_scheduler #(
        .NCH        (NCH),
        .CH_W       (CH_W),
        .SAMPLE_CYC (SAMPLE_CYC)
`ifdef SAR_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .CLK_S      (CLK_S),
        .RST        (RST),
        .REQ        (REQ),
        .GNT        (GNT),
        .CH_SEL     (CH_SEL),
        .SAMPLE     (SAMPLE),
        .CONV_START (CONV_START),
        .EOC        (EOC),
        .DIN        (DIN),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_DATA   (RES_DATA),
        .RES_CH     (RES_CH),
        .BUSY       (BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK_S = ~CLK_S;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_S);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"},     GNT, 0);
        chk({tag, "_chsel"},   CH_SEL, 0);
        chk({tag, "_sample"},  SAMPLE, 0);
        chk({tag, "_cstart"},  CONV_START, 0);
        chk({tag, "_rvalid"},  RES_VALID, 0);
        chk({tag, "_rdata"},   RES_DATA, 0);
        chk({tag, "_rch"},     RES_CH, 0);
        chk({tag, "_busy"},    BUSY, 0);
        chk({tag, "_tmo"},     TIMEOUT_ERR, 0);
    endtask

    // Reference round-robin: the pending channel at the smallest forward
    // distance from the pointer wins.
    function automatic int rr_pick(input logic [NCH-1:0] p, input int ptr);
        int best   = -1;
        int best_d = NCH;
        for (int c = 0; c < NCH; c++) begin
            if (p[c] && ((c - ptr + NCH) % NCH) < best_d) begin
                best   = c;
                best_d = (c - ptr + NCH) % NCH;
            end
        end
        return best;
    endfunction

    // Expect a grant of exp_ch on the very next edge.
    task automatic wait_gnt(input int exp_ch);
        int n = 0;
        do begin
            tick();
            n++;
        end while (GNT == '0 && n < 50);
        chk("gnt_latency", n, 1);
        chk("gnt_onehot", GNT, 1 << exp_ch);
        chk("gnt_chsel", CH_SEL, exp_ch);
        chk("gnt_sample", SAMPLE, 1);
        chk("gnt_busy", BUSY, 1);
        chk("gnt_slot_empty", RES_VALID, 0);
        mdl_ptr = (exp_ch + 1) % NCH;
    endtask

    // From the first SAMPLE cycle: check window length and start pulse, then
    // raise EOC after dly cycles in WAIT_EOC and check the captured result.
    task automatic finish_conv(input int ch, input logic [11:0] din, input int dly, input logic rdy);
        int cnt = 0;
        while (SAMPLE === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
            chk("gnt_pulse", GNT, 0);
        end
        chk("sample_len", cnt, SAMPLE_CYC);
        chk("conv_start", CONV_START, 1);
        tick();
        chk("conv_start_pulse", CONV_START, 0);
        chk("wait_busy", BUSY, 1);
        repeat (dly) begin
            tick();
            chk("no_early_res", RES_VALID, 0);
        end
        RES_READY = rdy;
        EOC = 1'b1;
        DIN = din;
        tick();
        chk("res_valid", RES_VALID, 1);
        chk("res_data", RES_DATA, din);
        chk("res_ch", RES_CH, ch);
        chk("res_idle", BUSY, 0);
        EOC = 1'b0;
        DIN = 12'($urandom);
    endtask

    initial begin
        logic [NCH-1:0] pend;
        logic [11:0]    d;
        int             bp;
        int             exp_ch;
        int             n;

        // Reset values while RST is held.
        #12;
        chk_reset("rst");
        tick();
        RST = 1'b0;
        RES_READY = 1'b1;

        // Fairness: all channels requesting continuously.
        REQ = '1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(k % NCH);
            finish_conv(k % NCH, 12'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
        REQ = '0;

        // Single request, result held under backpressure.
        REQ = 4'b0010;
        wait_gnt(1);
        REQ = '0;
        finish_conv(1, 12'hA5C, 2, 1'b0);
        REQ = 4'b0001;
        repeat (4) begin
            tick();
            chk("bp_no_gnt", GNT, 0);
            chk("bp_valid", RES_VALID, 1);
            chk("bp_data", RES_DATA, 12'hA5C);
            chk("bp_ch", RES_CH, 1);
        end
        RES_READY = 1'b1;
        wait_gnt(0);
        REQ = '0;
        finish_conv(0, 12'h123, 1, 1'b1);

        // EOC already high when WAIT_EOC is entered.
        REQ = 4'b0100;
        wait_gnt(2);
        REQ = '0;
        EOC = 1'b1;
        repeat (SAMPLE_CYC) tick();
        chk("hi_conv_start", CONV_START, 1);
        repeat (3) begin
            tick();
            chk("hi_no_capture", RES_VALID, 0);
            chk("hi_busy", BUSY, 1);
        end
        EOC = 1'b0;
        tick();
        chk("hi_no_capture_low", RES_VALID, 0);
        EOC = 1'b1;
        DIN = 12'h3C7;
        tick();
        chk("hi_valid", RES_VALID, 1);
        chk("hi_data", RES_DATA, 12'h3C7);
        chk("hi_ch", RES_CH, 2);
        EOC = 1'b0;

        // Reset while waiting for EOC.
        REQ = 4'b1000;
        wait_gnt(3);
        REQ = '0;
        repeat (SAMPLE_CYC + 2) tick();
        chk("mid_busy", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        chk_reset("mid_rst");
        tick();
        RST = 1'b0;
        mdl_ptr = 0;
        EOC = 1'b1;
        DIN = 12'hFFF;
        repeat (2) begin
            tick();
            chk("post_rst_no_res", RES_VALID, 0);
            chk("post_rst_idle", BUSY, 0);
        end
        EOC = 1'b0;

`ifdef SAR_SCHED_TIMEOUT_EN
        // Missing EOC: abort after TIMEOUT_CYC cycles, next channel served.
        REQ = 4'b0011;
        wait_gnt(0);
        REQ = 4'b0010;
        repeat (SAMPLE_CYC + 1) tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (TIMEOUT_ERR == 1'b0 && n < 200);
        chk("tmo_latency", n, TIMEOUT_CYC);
        chk("tmo_no_res", RES_VALID, 0);
        wait_gnt(1);
        chk("tmo_pulse", TIMEOUT_ERR, 0);
        REQ = '0;
        finish_conv(1, 12'h5A5, 0, 1'b1);
`else
        n = 0;
`endif

        // Randomized traffic against the round-robin model.
        pend = '0;
        for (int it = 0; it < 30; it++) begin
            pend = pend | NCH'($urandom_range(0, (1 << NCH) - 1));
            if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, NCH - 1)] = 1'b0;
            if (pend == '0) pend[$urandom_range(0, NCH - 1)] = 1'b1;
            REQ = pend;
            exp_ch = rr_pick(pend, mdl_ptr);
            wait_gnt(exp_ch);
            pend[exp_ch] = 1'b0;
            REQ = pend;
            bp = int'($urandom_range(0, 3));
            d = 12'($urandom);
            finish_conv(exp_ch, d, int'($urandom_range(0, 4)), (bp == 0));
            repeat (bp) begin
                tick();
                chk("rnd_bp_no_gnt", GNT, 0);
                chk("rnd_bp_valid", RES_VALID, 1);
                chk("rnd_bp_data", RES_DATA, d);
                chk("rnd_bp_ch", RES_CH, exp_ch);
            end
            RES_READY = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
